hilo_muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit for the EX stage. Accepts MULT/MULTU/DIV/DIVU

---
 rtl/hilo_muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle, with a pipeline stall request and flush cancel.
module hilo_muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter bit EARLY_ZERO_DIV = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  stall_req,
  output logic                  done,
  output logic                  we_hi,
  output logic                  we_lo,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_by_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] neg2_if(input logic [2*W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2*W-1:0]   acc_r;
  logic [W-1:0]     rem_r;
  logic [W-1:0]     opnd_r;
  logic             op_div_r, sign_a_r, sign_b_r, zero_div_r;
  logic             busy_r, done_r, dbz_r;
  logic [W-1:0]     hi_r, lo_r;

  logic             accept_s, in_sign_a_s, in_sign_b_s, in_zero_div_s;
  logic [W-1:0]     mag_a_s, mag_b_s;
  logic [W:0]       mul_sum_s;
  logic [2*W-1:0]   mul_nx_s;
  logic [W:0]       div_trial_s, div_diff_s;
  logic             div_ge_s;
  logic [W-1:0]     div_rem_nx_s, div_q_nx_s;
  logic [2*W-1:0]   prod_fix_s;
  logic [W-1:0]     fix_hi_s, fix_lo_s;

  assign accept_s      = (state_r == ST_IDLE) && start && !cancel;
  assign in_sign_a_s   = !op[0] && src_a[W-1];
  assign in_sign_b_s   = !op[0] && src_b[W-1];
  assign in_zero_div_s = op[1] && (src_b == {W{1'b0}});
  // |MIN_INT| wraps back to the same bit pattern, which reads correctly as unsigned 2^(W-1)
  assign mag_a_s       = neg_if(src_a, in_sign_a_s);
  assign mag_b_s       = neg_if(src_b, in_sign_b_s);

  // Shift-add step: conditionally add multiplicand to the upper half, shift right by one
  assign mul_sum_s = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
  assign mul_nx_s  = {mul_sum_s, acc_r[W-1:1]};

  // Restoring step; the remainder stays below the divisor, so the W+1-bit borrow is exact
  assign div_trial_s  = {rem_r, acc_r[W-1]};
  assign div_diff_s   = div_trial_s - {1'b0, opnd_r};
  assign div_ge_s     = !div_diff_s[W];
  assign div_rem_nx_s = div_ge_s ? div_diff_s[W-1:0] : div_trial_s[W-1:0];
  assign div_q_nx_s   = {acc_r[W-2:0], div_ge_s};

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nx_s = ST_IDLE;
        end else if (in_zero_div_s && EARLY_ZERO_DIV) begin
          state_nx_s = ST_FIX;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = ST_FIX;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (cancel) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Sign correction of the magnitude results; zero divide returns the dividend as given
  always_comb begin
    prod_fix_s = neg2_if(acc_r, sign_a_r ^ sign_b_r);
    fix_hi_s   = {W{1'b0}};
    fix_lo_s   = {W{1'b0}};
    if (!op_div_r) begin
      fix_hi_s = prod_fix_s[2*W-1:W];
      fix_lo_s = prod_fix_s[W-1:0];
    end else if (zero_div_r) begin
      fix_hi_s = neg_if(rem_r, sign_a_r);
      fix_lo_s = {W{1'b1}};
    end else begin
      fix_hi_s = neg_if(rem_r, sign_a_r);
      fix_lo_s = neg_if(acc_r[W-1:0], sign_a_r ^ sign_b_r);
    end
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == ST_CALC) || (state_nx_s == ST_FIX);
      done_r  <= (state_nx_s == ST_DONE);
      dbz_r   <= (state_nx_s == ST_DONE) && zero_div_r;
    end
  end

  // Operand capture, per-cycle arithmetic step and result commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*W){1'b0}};
      rem_r      <= {W{1'b0}};
      opnd_r     <= {W{1'b0}};
      op_div_r   <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      zero_div_r <= 1'b0;
      hi_r       <= {W{1'b0}};
      lo_r       <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_div_r   <= op[1];
            sign_a_r   <= in_sign_a_s;
            sign_b_r   <= in_sign_b_s;
            zero_div_r <= in_zero_div_s;
            cnt_r      <= CNT_W'(W - 1);
            if (op[1]) begin
              acc_r  <= {{W{1'b0}}, mag_a_s};
              opnd_r <= mag_b_s;
              // A skipped CALC leaves the dividend where a full zero-divide would have shifted it
              rem_r  <= (in_zero_div_s && EARLY_ZERO_DIV) ? mag_a_s : {W{1'b0}};
            end else begin
              acc_r  <= {{W{1'b0}}, mag_b_s};
              opnd_r <= mag_a_s;
              rem_r  <= {W{1'b0}};
            end
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r - CNT_W'(1'b1);
          if (op_div_r) begin
            acc_r <= {acc_r[2*W-1:W], div_q_nx_s};
            rem_r <= div_rem_nx_s;
          end else begin
            acc_r <= mul_nx_s;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_r;
  assign stall_req   = rst && (accept_s || busy_r);
  assign done        = done_r;
  assign we_hi       = done_r;
  assign we_lo       = done_r;
  assign div_by_zero = dbz_r;
  assign hi_out      = hi_r;
  assign lo_out      = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases, randomized ops against an
// arithmetic reference model, cancel, back-to-back and reset scenarios.
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic        clk, rst, start, start0, cancel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_req, done, we_hi, we_lo, div_by_zero;
  logic [31:0] hi_out, lo_out;
  logic        busy0, stall_req0, done0, we_hi0, we_lo0, div_by_zero0;
  logic [31:0] hi_out0, lo_out0;
  int          n_cmp = 0;
  int          n_err = 0;

  hilo_muldiv_unit #(.DATA_WIDTH(W), .EARLY_ZERO_DIV(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .stall_req(stall_req), .done(done), .we_hi(we_hi),
    .we_lo(we_lo), .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero));

  hilo_muldiv_unit #(.DATA_WIDTH(W), .EARLY_ZERO_DIV(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy0), .stall_req(stall_req0), .done(done0), .we_hi(we_hi0),
    .we_lo(we_lo0), .hi_out(hi_out0), .lo_out(lo_out0), .div_by_zero(div_by_zero0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = 32'h0;
    lo  = 32'h0;
    case (o)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb; hi = 32'(r); lo = 32'(q);
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for the accepting edge, then scramble the now don't-care inputs
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit use0);
    op = o; src_a = a; src_b = b;
    if (use0) start0 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start0 = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_done(input bit use0, input int noise, input int maxc, output int lat);
    lat = -1;
    for (int c = 1; c <= maxc; c++) begin
      if ((use0 ? done0 : done) === 1'b1) begin
        lat = c;
        break;
      end
      if (c <= noise) begin
        start = 1'($urandom_range(0, 1)); op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; start0 = 1'b0; cancel = 1'b0; op = 2'b01;
    src_a = 32'h5; src_b = 32'h7;
    tick(); tick();
    n_cmp++;
    if ({busy, stall_req, done, we_hi, we_lo, div_by_zero, hi_out, lo_out} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, stall_req, done, we_hi, we_lo, div_by_zero, hi_out, lo_out});
    end
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy, stall_req, done, busy0, done0} !== 5'h0) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 00000", {busy, stall_req, done, busy0, done0});
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] t_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'h1234};
    logic [31:0] t_b  [6] = '{32'hFFFF_FFFF, 32'h7, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] t_hi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1234};
    logic [31:0] t_lo [6] = '{32'h1, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h3, 32'h8000_0000, 32'hFFFF_FFFF};
    logic        t_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          t_l  [6] = '{LAT, LAT, LAT, LAT, LAT, 2};
    int          lat;
    for (int i = 0; i < 6; i++) begin
      launch(t_op[i], t_a[i], t_b[i], 1'b0);
      wait_done(1'b0, 0, 60, lat);
      n_cmp++;
      if (lat !== t_l[i]) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, t_l[i]); end
      n_cmp++;
      if ({hi_out, lo_out} !== {t_hi[i], t_lo[i]}) begin
        n_err++; $display("FAIL dir%0d_result: got %h_%h expected %h_%h", i, hi_out, lo_out, t_hi[i], t_lo[i]);
      end
      n_cmp++;
      if ({div_by_zero, we_hi, we_lo} !== {t_z[i], 2'b11}) begin
        n_err++; $display("FAIL dir%0d_flags: got %b expected %b", i, {div_by_zero, we_hi, we_lo}, {t_z[i], 2'b11});
      end
      tick();
      n_cmp++;
      if ({done, we_hi, div_by_zero} !== 3'b000) begin
        n_err++; $display("FAIL dir%0d_pulse: got %b expected 000", i, {done, we_hi, div_by_zero});
      end
    end
  endtask

  task automatic test_zero_div_full();
    logic [31:0] t_a [2] = '{32'h0000_1234, 32'h8000_0000};
    logic [1:0]  t_o [2] = '{2'b10, 2'b11};
    int          lat;
    for (int i = 0; i < 2; i++) begin
      launch(t_o[i], t_a[i], 32'h0, 1'b1);
      n_cmp++;
      if ({busy0, busy} !== 2'b10) begin n_err++; $display("FAIL zdiv%0d_busy: got %b expected 10", i, {busy0, busy}); end
      wait_done(1'b1, 0, 60, lat);
      n_cmp++;
      if (lat !== LAT) begin n_err++; $display("FAIL zdiv%0d_latency: got %0d expected %0d", i, lat, LAT); end
      n_cmp++;
      if ({div_by_zero0, hi_out0, lo_out0} !== {1'b1, t_a[i], 32'hFFFF_FFFF}) begin
        n_err++; $display("FAIL zdiv%0d_result: got %b %h %h expected 1 %h ffffffff", i, div_by_zero0, hi_out0, lo_out0, t_a[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, e_hi, e_lo;
    logic        e_z;
    int          e_lat, lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3)); a = pick(); b = pick();
      ref_model(o, a, b, e_hi, e_lo, e_z);
      e_lat = (o[1] && b == 32'h0) ? 2 : LAT;
      launch(o, a, b, 1'b0);
      n_cmp++;
      if ({busy, stall_req} !== 2'b11) begin n_err++; $display("FAIL rnd%0d_busy: got %b expected 11", i, {busy, stall_req}); end
      wait_done(1'b0, (e_lat == LAT) ? 20 : 0, 60, lat);
      n_cmp++;
      if (lat !== e_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, e_lat); end
      n_cmp++;
      if ({div_by_zero, hi_out, lo_out} !== {e_z, e_hi, e_lo}) begin
        n_err++;
        $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %b %h %h expected %b %h %h",
                 i, o, a, b, div_by_zero, hi_out, lo_out, e_z, e_hi, e_lo);
      end
      tick();
    end
  endtask

  task automatic test_cancel();
    int lat;
    bit seen;
    launch(2'b01, 32'd5, 32'd6, 1'b0);
    wait_done(1'b0, 0, 60, lat);
    tick();
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) tick();
    cancel = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL cancel_calc_busy10: got %b expected 1", busy); end
    tick();
    cancel = 1'b0;
    n_cmp++;
    if ({busy, stall_req} !== 2'b00) begin n_err++; $display("FAIL cancel_calc_busy11: got %b expected 00", {busy, stall_req}); end
    seen = 1'b0;
    repeat (40) begin if (done) seen = 1'b1; tick(); end
    n_cmp++;
    if ({seen, hi_out, lo_out} !== {1'b0, 32'd0, 32'd30}) begin
      n_err++; $display("FAIL cancel_calc_hold: got %b %h %h expected 0 0 1e", seen, hi_out, lo_out);
    end
    launch(2'b11, 32'd100, 32'd7, 1'b0);
    wait_done(1'b0, 0, 60, lat);
    n_cmp++;
    if ({lat, hi_out, lo_out} !== {LAT, 32'd2, 32'd14}) begin
      n_err++; $display("FAIL cancel_next_op: got %0d %h %h expected %0d 2 e", lat, hi_out, lo_out, LAT);
    end
    tick();
    launch(2'b00, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0);
    repeat (32) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    seen = 1'b0;
    repeat (40) begin if (done || busy) seen = 1'b1; tick(); end
    n_cmp++;
    if ({seen, hi_out, lo_out} !== {1'b0, 32'd2, 32'd14}) begin
      n_err++; $display("FAIL cancel_fix_hold: got %b %h %h expected 0 2 e", seen, hi_out, lo_out);
    end
    op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1; cancel = 1'b1;
    n_cmp++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL cancel_idle_stall: got %b expected 0", stall_req); end
    tick();
    start = 1'b0; cancel = 1'b0;
    seen = 1'b0;
    repeat (40) begin if (done || busy) seen = 1'b1; tick(); end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL cancel_idle_accept: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(2'b11, 32'd1000, 32'd3, 1'b0);
    wait_done(1'b0, 0, 60, lat);
    n_cmp++;
    if ({stall_req, busy} !== 2'b00) begin n_err++; $display("FAIL b2b_done_stall: got %b expected 00", {stall_req, busy}); end
    op = 2'b01; src_a = 32'd2; src_b = 32'd2; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done, hi_out, lo_out} !== {2'b00, 32'd1, 32'd333}) begin
      n_err++; $display("FAIL b2b_done_ignores: got %b %b %h %h expected 0 0 1 14d", busy, done, hi_out, lo_out);
    end
    launch(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_done(1'b0, 0, 60, lat);
    tick();
    launch(2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    wait_done(1'b0, 0, 60, lat);
    n_cmp++;
    if ({lat, hi_out, lo_out} !== {LAT, 32'h0000_0000, 32'h8000_0000}) begin
      n_err++; $display("FAIL b2b_second: got %0d %h %h expected %0d 0 80000000", lat, hi_out, lo_out, LAT);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] e_hi, e_lo;
    logic        e_z;
    int          lat;
    launch(2'b01, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b0);
    repeat (14) tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, stall_req, done, we_hi, we_lo, div_by_zero, hi_out, lo_out} !== 70'h0) begin
      n_err++; $display("FAIL reset_mid_outputs: got %h expected 0",
                        {busy, stall_req, done, we_hi, we_lo, div_by_zero, hi_out, lo_out});
    end
    tick();
    rst = 1'b1;
    tick();
    ref_model(2'b10, 32'hFFFF_FF9C, 32'd7, e_hi, e_lo, e_z);
    launch(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0);
    wait_done(1'b0, 0, 60, lat);
    n_cmp++;
    if ({lat, e_z, hi_out, lo_out} !== {LAT, div_by_zero, e_hi, e_lo}) begin
      n_err++; $display("FAIL reset_mid_fresh: got %0d %h %h expected %0d %h %h", lat, hi_out, lo_out, LAT, e_hi, e_lo);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_div_full();
    test_random();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
